// File: rtl/frv_mem_arbiter_if.sv
`timescale 1ns/1ps
// Shared req/gnt/recv/ack memory bus used on both sides of frv_mem_arbiter.
// The master modport issues requests and consumes responses; the slave modport serves them.
interface frv_mem_arbiter_if;
    logic        req;
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        gnt;
    logic        recv;
    logic        error;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, wen, strb, wdata, addr, ack,
        input  gnt, recv, error, rdata
    );

    modport slave (
        input  req, wen, strb, wdata, addr, ack,
        output gnt, recv, error, rdata
    );
endinterface

// File: rtl/frv_mem_arbiter.sv
`timescale 1ns/1ps
// Two-master (imem/dmem) to one-slave memory arbiter with in-order response routing.
// Define FRV_MEM_ARB_RR_EN for round-robin arbitration; default is fixed dmem priority.
module frv_mem_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    frv_mem_arbiter_if.slave  imem,
    frv_mem_arbiter_if.slave  dmem,
    frv_mem_arbiter_if.master mem,
    output logic              err_spurious
);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING) + 1;

    typedef enum logic { OWNER_IMEM = 1'b0, OWNER_DMEM = 1'b1 } owner_e;
    typedef enum logic [1:0] { LOCK_NONE, LOCK_IMEM, LOCK_DMEM } lock_e;

    lock_e              lock_q;
    lock_e              lock_next;
    owner_e             free_winner;
    owner_e             winner;
    owner_e             head;
    logic               winner_req;
    logic               req_out;
    logic               grant;
    logic               ack_out;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [OUTSTANDING-1:0] tag_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(OUTSTANDING - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

`ifdef FRV_MEM_ARB_RR_EN
    owner_e rr_ptr_q;

    always_comb begin
        free_winner = dmem.req ? OWNER_DMEM : OWNER_IMEM;
        if (imem.req && dmem.req)
            free_winner = rr_ptr_q;
    end

    // The pointer hands priority to whichever master was not just granted.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn)
            rr_ptr_q <= OWNER_IMEM;
        else if (grant)
            rr_ptr_q <= (winner == OWNER_IMEM) ? OWNER_DMEM : OWNER_IMEM;
    end
`else
    always_comb free_winner = dmem.req ? OWNER_DMEM : OWNER_IMEM;
`endif

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn)
            lock_q <= LOCK_NONE;
        else
            lock_q <= lock_next;
    end

    // A stalled request pins the selection so the bus fields never change before its grant.
    always_comb begin
        lock_next = lock_q;
        winner    = free_winner;
        case (lock_q)
            LOCK_IMEM: winner = OWNER_IMEM;
            LOCK_DMEM: winner = OWNER_DMEM;
            default:   winner = free_winner;
        endcase
        winner_req = (winner == OWNER_DMEM) ? dmem.req : imem.req;
        req_out    = winner_req && !fifo_full;
        grant      = req_out && mem.gnt;
        if (req_out && !mem.gnt)
            lock_next = (winner == OWNER_DMEM) ? LOCK_DMEM : LOCK_IMEM;
        else if (grant)
            lock_next = LOCK_NONE;
    end

    assign mem.req   = req_out;
    assign mem.wen   = (winner == OWNER_DMEM) ? dmem.wen   : imem.wen;
    assign mem.strb  = (winner == OWNER_DMEM) ? dmem.strb  : imem.strb;
    assign mem.wdata = (winner == OWNER_DMEM) ? dmem.wdata : imem.wdata;
    assign mem.addr  = (winner == OWNER_DMEM) ? dmem.addr  : imem.addr;
    assign imem.gnt  = grant && (winner == OWNER_IMEM);
    assign dmem.gnt  = grant && (winner == OWNER_DMEM);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(OUTSTANDING));
    assign head       = owner_e'(tag_q[rd_ptr_q]);

    // With nothing outstanding a response has no owner, so it is swallowed.
    always_comb begin
        imem.recv = 1'b0;
        dmem.recv = 1'b0;
        ack_out   = mem.recv;
        if (!fifo_empty) begin
            imem.recv = mem.recv && (head == OWNER_IMEM);
            dmem.recv = mem.recv && (head == OWNER_DMEM);
            ack_out   = (head == OWNER_DMEM) ? dmem.ack : imem.ack;
        end
    end

    assign mem.ack    = ack_out;
    assign imem.rdata = mem.rdata;
    assign dmem.rdata = mem.rdata;
    assign imem.error = mem.error;
    assign dmem.error = mem.error;

    assign push = grant;
    assign pop  = mem.recv && ack_out && !fifo_empty;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= winner;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop)
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
            if (mem.recv && fifo_empty)
                err_spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_frv_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for frv_mem_arbiter: grant order and response routing are
// checked against address and response scoreboards filled when stimulus is driven.
module tb_frv_mem_arbiter;
    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    logic err_spurious;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [31:0] addr_q[$];

    frv_mem_arbiter_if imem_bus();
    frv_mem_arbiter_if dmem_bus();
    frv_mem_arbiter_if mem_bus();

    frv_mem_arbiter #(.OUTSTANDING(2)) dut (
        .g_clk       (g_clk),
        .g_resetn    (g_resetn),
        .imem        (imem_bus),
        .dmem        (dmem_bus),
        .mem         (mem_bus),
        .err_spurious(err_spurious)
    );

    always #5 g_clk = ~g_clk;

    task automatic idle_inputs();
        imem_bus.req = 1'b0; imem_bus.wen = 1'b0; imem_bus.strb = 4'h0;
        imem_bus.wdata = '0; imem_bus.addr = '0; imem_bus.ack = 1'b0;
        dmem_bus.req = 1'b0; dmem_bus.wen = 1'b0; dmem_bus.strb = 4'h0;
        dmem_bus.wdata = '0; dmem_bus.addr = '0; dmem_bus.ack = 1'b0;
        mem_bus.gnt = 1'b0; mem_bus.recv = 1'b0; mem_bus.error = 1'b0; mem_bus.rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge g_clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rsp_q.delete();
        addr_q.delete();
        g_resetn = 1'b0;
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        g_resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        idle_inputs();
        g_resetn = 1'b0;
        #3;
        obs = {err_spurious, mem_bus.req, imem_bus.gnt, dmem_bus.gnt,
               imem_bus.recv, dmem_bus.recv, mem_bus.ack};
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%b want=%b", obs, 7'b0);
        end
        do_reset();
        @(negedge g_clk);
        obs = {err_spurious, mem_bus.req, imem_bus.gnt, dmem_bus.gnt,
               imem_bus.recv, dmem_bus.recv, mem_bus.ack};
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_release got=%b want=%b", obs, 7'b0);
        end
    endtask

    task automatic test_single_read();
        logic [31:0] exp_addr;
        rsp_t        r;
        do_reset();
        next_cycle();
        imem_bus.req = 1'b1; imem_bus.addr = 32'h8000_0000; mem_bus.gnt = 1'b1;
        addr_q.push_back(32'h8000_0000);
        rsp_q.push_back('{1'b0, 32'h0000_0013});
        @(negedge g_clk);
        total++;
        if ({mem_bus.req, imem_bus.gnt, dmem_bus.gnt} !== 3'b110) begin
            bad++;
            $display("[TB] FAIL single_gnt got=%b want=110", {mem_bus.req, imem_bus.gnt, dmem_bus.gnt});
        end
        exp_addr = addr_q.pop_front();
        total++;
        if (mem_bus.addr !== exp_addr) begin
            bad++;
            $display("[TB] FAIL single_addr got=%h want=%h", mem_bus.addr, exp_addr);
        end
        next_cycle();
        imem_bus.req = 1'b0; mem_bus.gnt = 1'b0;
        @(negedge g_clk);
        total++;
        if ({imem_bus.gnt, imem_bus.recv, dmem_bus.recv} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL single_quiet got=%b want=000", {imem_bus.gnt, imem_bus.recv, dmem_bus.recv});
        end
        next_cycle();
        mem_bus.recv = 1'b1; mem_bus.rdata = 32'h0000_0013; imem_bus.ack = 1'b1;
        @(negedge g_clk);
        r = rsp_q.pop_front();
        total++;
        if ({imem_bus.recv, dmem_bus.recv, mem_bus.ack} !== {~r.owner, r.owner, 1'b1}) begin
            bad++;
            $display("[TB] FAIL single_route got=%b want=%b",
                     {imem_bus.recv, dmem_bus.recv, mem_bus.ack}, {~r.owner, r.owner, 1'b1});
        end
        total++;
        if (imem_bus.rdata !== r.rdata) begin
            bad++;
            $display("[TB] FAIL single_rdata got=%h want=%h", imem_bus.rdata, r.rdata);
        end
        next_cycle();
        mem_bus.recv = 1'b0; imem_bus.ack = 1'b0;
        @(negedge g_clk);
        total++;
        if ({err_spurious, imem_bus.recv, dmem_bus.recv} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL single_after got=%b want=000", {err_spurious, imem_bus.recv, dmem_bus.recv});
        end
    endtask

    task automatic test_priority();
        logic        first;
        logic [31:0] exp_addr;
        rsp_t        r;
`ifdef FRV_MEM_ARB_RR_EN
        first = 1'b0;
`else
        first = 1'b1;
`endif
        do_reset();
        next_cycle();
        imem_bus.req = 1'b1; imem_bus.addr = 32'h8000_0004;
        dmem_bus.req = 1'b1; dmem_bus.wen = 1'b1; dmem_bus.strb = 4'hF;
        dmem_bus.wdata = 32'hDEAD_BEEF; dmem_bus.addr = 32'h0000_2000;
        mem_bus.gnt = 1'b1;
        addr_q.push_back(first ? 32'h0000_2000 : 32'h8000_0004);
        addr_q.push_back(first ? 32'h8000_0004 : 32'h0000_2000);
        rsp_q.push_back('{first, 32'h1111_0001});
        rsp_q.push_back('{~first, 32'h2222_0002});
        for (int k = 0; k < 2; k++) begin
            logic owner;
            owner = (k == 0) ? first : ~first;
            @(negedge g_clk);
            exp_addr = addr_q.pop_front();
            total++;
            if ({mem_bus.addr, mem_bus.wen, imem_bus.gnt, dmem_bus.gnt} !== {exp_addr, owner, ~owner, owner}) begin
                bad++;
                $display("[TB] FAIL prio_grant%0d got=%h/%b%b%b want=%h/%b%b%b", k,
                         mem_bus.addr, mem_bus.wen, imem_bus.gnt, dmem_bus.gnt,
                         exp_addr, owner, ~owner, owner);
            end
            next_cycle();
            if (owner) dmem_bus.req = 1'b0;
            else       imem_bus.req = 1'b0;
        end
        mem_bus.gnt = 1'b0;
        imem_bus.ack = 1'b1; dmem_bus.ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mem_bus.recv = 1'b1;
            mem_bus.rdata = (k == 0) ? 32'h1111_0001 : 32'h2222_0002;
            @(negedge g_clk);
            r = rsp_q.pop_front();
            total++;
            if ({imem_bus.recv, dmem_bus.recv, mem_bus.ack} !== {~r.owner, r.owner, 1'b1}
                || dmem_bus.rdata !== r.rdata) begin
                bad++;
                $display("[TB] FAIL prio_resp%0d got=%b/%h want=%b/%h", k,
                         {imem_bus.recv, dmem_bus.recv, mem_bus.ack}, dmem_bus.rdata,
                         {~r.owner, r.owner, 1'b1}, r.rdata);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        logic [31:0] exp_addr;
        do_reset();
        next_cycle();
        imem_bus.req = 1'b1; imem_bus.addr = 32'h8000_0004;
        addr_q.push_back(32'h8000_0004);
        addr_q.push_back(32'h0000_2000);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                dmem_bus.req = 1'b1; dmem_bus.addr = 32'h0000_2000;
            end
            @(negedge g_clk);
            total++;
            if ({mem_bus.addr, imem_bus.gnt, dmem_bus.gnt} !== {32'h8000_0004, 2'b00}) begin
                bad++;
                $display("[TB] FAIL lock_hold%0d got=%h/%b%b want=80000004/00", c,
                         mem_bus.addr, imem_bus.gnt, dmem_bus.gnt);
            end
            next_cycle();
        end
        mem_bus.gnt = 1'b1;
        @(negedge g_clk);
        exp_addr = addr_q.pop_front();
        total++;
        if ({mem_bus.addr, imem_bus.gnt, dmem_bus.gnt} !== {exp_addr, 2'b10}) begin
            bad++;
            $display("[TB] FAIL lock_grant got=%h/%b%b want=%h/10",
                     mem_bus.addr, imem_bus.gnt, dmem_bus.gnt, exp_addr);
        end
        next_cycle();
        imem_bus.req = 1'b0;
        @(negedge g_clk);
        exp_addr = addr_q.pop_front();
        total++;
        if ({mem_bus.addr, imem_bus.gnt, dmem_bus.gnt} !== {exp_addr, 2'b01}) begin
            bad++;
            $display("[TB] FAIL lock_next got=%h/%b%b want=%h/01",
                     mem_bus.addr, imem_bus.gnt, dmem_bus.gnt, exp_addr);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr;
        rsp_t        r;
        do_reset();
        next_cycle();
        mem_bus.gnt = 1'b1;
        imem_bus.req = 1'b1; imem_bus.addr = 32'h8000_0100;
        addr_q.push_back(32'h8000_0100); rsp_q.push_back('{1'b0, 32'hA000_0000});
        @(negedge g_clk);
        exp_addr = addr_q.pop_front();
        total++;
        if ({mem_bus.addr, imem_bus.gnt} !== {exp_addr, 1'b1}) begin
            bad++;
            $display("[TB] FAIL b2b_first got=%h/%b want=%h/1", mem_bus.addr, imem_bus.gnt, exp_addr);
        end
        next_cycle();
        imem_bus.req = 1'b0;
        dmem_bus.req = 1'b1; dmem_bus.addr = 32'h0000_2100;
        addr_q.push_back(32'h0000_2100); rsp_q.push_back('{1'b1, 32'hA000_0001});
        @(negedge g_clk);
        exp_addr = addr_q.pop_front();
        total++;
        if ({mem_bus.addr, dmem_bus.gnt} !== {exp_addr, 1'b1}) begin
            bad++;
            $display("[TB] FAIL b2b_second got=%h/%b want=%h/1", mem_bus.addr, dmem_bus.gnt, exp_addr);
        end
        next_cycle();
        dmem_bus.req = 1'b0;
        imem_bus.req = 1'b1; imem_bus.addr = 32'h8000_0104;
        addr_q.push_back(32'h8000_0104); rsp_q.push_back('{1'b0, 32'hA000_0002});
        for (int c = 0; c < 2; c++) begin
            @(negedge g_clk);
            total++;
            if ({mem_bus.req, imem_bus.gnt} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL b2b_full%0d got=%b want=00", c, {mem_bus.req, imem_bus.gnt});
            end
            next_cycle();
        end
        mem_bus.recv = 1'b1; mem_bus.rdata = 32'hA000_0000;
        imem_bus.ack = 1'b1; dmem_bus.ack = 1'b1;
        @(negedge g_clk);
        r = rsp_q.pop_front();
        total++;
        if ({imem_bus.recv, dmem_bus.recv, mem_bus.ack, mem_bus.req} !== {~r.owner, r.owner, 2'b10}
            || imem_bus.rdata !== r.rdata) begin
            bad++;
            $display("[TB] FAIL b2b_pop got=%b/%h want=%b/%h",
                     {imem_bus.recv, dmem_bus.recv, mem_bus.ack, mem_bus.req}, imem_bus.rdata,
                     {~r.owner, r.owner, 2'b10}, r.rdata);
        end
        next_cycle();
        mem_bus.recv = 1'b0;
        @(negedge g_clk);
        exp_addr = addr_q.pop_front();
        total++;
        if ({mem_bus.req, imem_bus.gnt, mem_bus.addr} !== {2'b11, exp_addr}) begin
            bad++;
            $display("[TB] FAIL b2b_resume got=%b/%h want=11/%h",
                     {mem_bus.req, imem_bus.gnt}, mem_bus.addr, exp_addr);
        end
        next_cycle();
        imem_bus.req = 1'b0; mem_bus.gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_bus.recv = 1'b1;
            mem_bus.rdata = (k == 0) ? 32'hA000_0001 : 32'hA000_0002;
            @(negedge g_clk);
            r = rsp_q.pop_front();
            total++;
            if ({imem_bus.recv, dmem_bus.recv, mem_bus.ack} !== {~r.owner, r.owner, 1'b1}
                || imem_bus.rdata !== r.rdata) begin
                bad++;
                $display("[TB] FAIL b2b_order%0d got=%b/%h want=%b/%h", k,
                         {imem_bus.recv, dmem_bus.recv, mem_bus.ack}, imem_bus.rdata,
                         {~r.owner, r.owner, 1'b1}, r.rdata);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge g_clk);
        total++;
        if (err_spurious !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_no_spurious got=%b want=0", err_spurious);
        end
    endtask

    task automatic test_ack_stall();
        rsp_t r;
        do_reset();
        next_cycle();
        imem_bus.req = 1'b1; imem_bus.addr = 32'h8000_0200; mem_bus.gnt = 1'b1;
        rsp_q.push_back('{1'b0, 32'h0000_0293});
        @(negedge g_clk);
        total++;
        if (imem_bus.gnt !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stall_issue got=%b want=1", imem_bus.gnt);
        end
        next_cycle();
        imem_bus.req = 1'b0; mem_bus.gnt = 1'b0;
        mem_bus.recv = 1'b1; mem_bus.rdata = 32'h0000_0293;
        imem_bus.ack = 1'b0; dmem_bus.ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge g_clk);
            total++;
            if ({imem_bus.recv, dmem_bus.recv, mem_bus.ack} !== 3'b100) begin
                bad++;
                $display("[TB] FAIL stall_hold%0d got=%b want=100", c,
                         {imem_bus.recv, dmem_bus.recv, mem_bus.ack});
            end
            next_cycle();
        end
        imem_bus.ack = 1'b1;
        @(negedge g_clk);
        r = rsp_q.pop_front();
        total++;
        if ({imem_bus.recv, dmem_bus.recv, mem_bus.ack} !== {~r.owner, r.owner, 1'b1}
            || imem_bus.rdata !== r.rdata) begin
            bad++;
            $display("[TB] FAIL stall_release got=%b/%h want=%b/%h",
                     {imem_bus.recv, dmem_bus.recv, mem_bus.ack}, imem_bus.rdata,
                     {~r.owner, r.owner, 1'b1}, r.rdata);
        end
        next_cycle();
        idle_inputs();
        @(negedge g_clk);
        total++;
        if (err_spurious !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_no_spurious got=%b want=0", err_spurious);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        next_cycle();
        mem_bus.recv = 1'b1; mem_bus.rdata = 32'h0000_0BAD;
        @(negedge g_clk);
        total++;
        if ({mem_bus.ack, imem_bus.recv, dmem_bus.recv} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL spur_discard got=%b want=100", {mem_bus.ack, imem_bus.recv, dmem_bus.recv});
        end
        next_cycle();
        mem_bus.recv = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge g_clk);
            total++;
            if (err_spurious !== 1'b1) begin
                bad++;
                $display("[TB] FAIL spur_sticky%0d got=%b want=1", c, err_spurious);
            end
        end
        next_cycle();
        imem_bus.req = 1'b1; imem_bus.addr = 32'h8000_0300; mem_bus.gnt = 1'b1;
        next_cycle();
        imem_bus.req = 1'b0; mem_bus.gnt = 1'b0;
        @(negedge g_clk);
        #2;
        g_resetn = 1'b0;
        #1;
        total++;
        if ({err_spurious, mem_bus.ack, imem_bus.gnt, dmem_bus.gnt, imem_bus.recv, dmem_bus.recv} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL spur_async_reset got=%b want=000000",
                     {err_spurious, mem_bus.ack, imem_bus.gnt, dmem_bus.gnt, imem_bus.recv, dmem_bus.recv});
        end
        @(negedge g_clk);
        g_resetn = 1'b1;
        next_cycle();
        mem_bus.recv = 1'b1; imem_bus.ack = 1'b0;
        @(negedge g_clk);
        total++;
        if ({mem_bus.ack, imem_bus.recv} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL spur_stale got=%b want=10", {mem_bus.ack, imem_bus.recv});
        end
        next_cycle();
        mem_bus.recv = 1'b0;
        @(negedge g_clk);
        total++;
        if (err_spurious !== 1'b1) begin
            bad++;
            $display("[TB] FAIL spur_stale_flag got=%b want=1", err_spurious);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_lock();
        test_back_to_back();
        test_ack_stall();
        test_spurious();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/frv_mem_arbiter.md
# frv_mem_arbiter

Two-master, one-slave memory arbiter that sits directly downstream of `frv_core`. It merges the core's instruction port (`imem_*`) and data port (`dmem_*`) onto a single memory bus using the same req/gnt/recv/ack protocol. A small in-order tag FIFO records which master owns each outstanding transaction, so every response is routed back to its issuer. Requests and responses pass through combinationally; the only added state is the arbitration lock, the order FIFO and the round-robin pointer.

## Interface
- `OUTSTANDING`, 2, max accepted-but-unanswered transactions (order FIFO depth, power of 2, ≥1)
- `g_clk` in 1: global clock
- `g_resetn` in 1: reset, asynchronous assert, active-low
- `imem_req`/`imem_wen` in 1, `imem_strb` in 4, `imem_wdata`/`imem_addr` in 32: instruction-side request from core
- `imem_gnt` out 1: instruction request accepted
- `imem_recv` out 1, `imem_error` out 1, `imem_rdata` out 32: instruction response
- `imem_ack` in 1: core consumes instruction response
- `dmem_*`: identical set for the data side
- `mem_req`/`mem_wen` out 1, `mem_strb` out 4, `mem_wdata`/`mem_addr` out 32: merged request to memory
- `mem_gnt` in 1: memory accepts request
- `mem_recv` in 1, `mem_error` in 1, `mem_rdata` in 32: memory response
- `mem_ack` out 1: arbiter consumes memory response
- `err_spurious` out 1: sticky flag, response received with no outstanding transaction

## Operation
- Request transfer occurs on `req & gnt`. Response transfer occurs on `recv & ack`. Masters hold request fields stable until granted.
- Arbitration:
  - Candidates are masters with `req=1`.
  - Unlocked winner is fixed priority: dmem over imem (see Configuration).
  - `mem_req = winner_req & !fifo_full`. All `mem_*` request fields are muxed from the winner.
  - `<master>_gnt = mem_gnt & mem_req & (winner==master)`. The loser always sees `gnt=0`.
- Lock: if `mem_req=1` and `mem_gnt=0`, register the winner. The selection stays locked until that request is granted, even if the other master raises a higher-priority request. The lock clears on the granting cycle.
- Order FIFO: entries are 1-bit owner tags (0=imem, 1=dmem).
  - Push the winner on `mem_req & mem_gnt`.
  - Pop on `mem_recv & mem_ack`.
  - Push is blocked when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, pointers both advance.
- Response routing while the FIFO is non-empty, with head tag H:
  - `<H>_recv = mem_recv`.
  - `mem_ack = <H>_ack`.
  - rdata/error are broadcast to both masters; only `<H>_recv` qualifies them.
- Empty FIFO with `mem_recv=1`: `mem_ack=1` (response discarded), `err_spurious` set. It clears only on reset.
- Pointers wrap modulo `OUTSTANDING`. The count is `log2(OUTSTANDING)+1` bits.

## Timing
- Reset values:
  - FIFO empty, lock clear, round-robin pointer = imem next.
  - `err_spurious=0`, `mem_req=0`, `imem_gnt=0`, `dmem_gnt=0`, `imem_recv=0`, `dmem_recv=0`, `mem_ack=0`.
  - Data outputs follow inputs combinationally.
- Zero added latency: `mem_req`, `mem_*` fields and `*_gnt` are combinational from inputs and lock state. Responses are also combinational.
- A request granted in cycle N may receive its response in cycle N+1 or later. A same-cycle response to a request being granted is not supported: the FIFO is still empty, so it counts as spurious.
- Full FIFO: `mem_req=0` until a pop is registered. Resumes the cycle after the pop.
- Reset mid-operation clears all outstanding tags. Memory responses for pre-reset transactions raise `err_spurious`.

## Configuration
- `FRV_MEM_ARB_RR_EN` defined: unlocked winner is round-robin. After each grant the pointer moves to the other master. With both requesting, the pointer's master wins.
- Undefined: fixed dmem priority, no pointer flop.
- Lock, FIFO and routing behaviour are identical in both builds.

## Test plan
- Single imem read, addr 0x8000_0000, `mem_gnt` same cycle, `mem_recv` 2 cycles later with rdata 0x0000_0013 → `imem_gnt=1` once, `imem_recv=1` with 0x0000_0013, `dmem_recv` never asserts.
- Both request in the same cycle (imem 0x8000_0004, dmem 0x0000_2000 write strb 0xF), fixed-priority build → dmem granted first, imem next cycle. Responses R1, R2 are routed dmem then imem. In the RR build from reset, imem is granted first.
- imem request stalled with `mem_gnt=0` for 3 cycles, dmem raises req in cycle 1 → `mem_addr` stays 0x8000_0004 until grant, then dmem is served.
- `OUTSTANDING=2`, three back-to-back grants with no response → third `mem_req=0` until the first `mem_recv & mem_ack`. Then it is issued the next cycle, and order is preserved.
- Head owner imem holds `imem_ack=0` for 2 cycles with `mem_recv=1` → `mem_ack=0`, `imem_recv` held 2 cycles, no pop, and `dmem_ack=1` is ignored.
- `mem_recv=1` with the FIFO empty → `mem_ack=1`, `err_spurious=1` persisting. Assert `g_resetn=0` mid-clock → all flags and the FIFO clear immediately.
